// File: rtl/j_mac_sequencer_pkg.sv
// Shared Jerry DSP definitions for the MAC sequencer: FSM state encoding,
// accumulator width and the saturation clamp constants.
package j_mac_sequencer_pkg;

   localparam int unsigned ACC_W  = 40;
   localparam int unsigned DATA_W = 32;

   localparam logic [DATA_W-1:0] SAT_POS32 = 32'h7FFF_FFFF;
   localparam logic [DATA_W-1:0] SAT_NEG32 = 32'h8000_0000;
   localparam logic [DATA_W-1:0] SAT_POS16 = 32'h0000_7FFF;
   localparam logic [DATA_W-1:0] SAT_NEG16 = 32'hFFFF_8000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_RESULT
   } state_t;

endpackage

// File: rtl/j_saturate.sv
// Jerry accumulator saturation: clamps a 40-bit accumulator to signed 32-bit
// range (satszp=1) or clamps its low 32 bits to signed 16-bit range (satszp=0).
// Ports: d = acc[31:0], accum_32..accum_39 = acc[39:32], satszp = mode,
//        q_c = clamped (or passed-through) result, purely combinational.
module j_saturate
   import j_mac_sequencer_pkg::*;
(
   input  logic [DATA_W-1:0] d,
   input  logic              accum_32,
   input  logic              accum_33,
   input  logic              accum_34,
   input  logic              accum_35,
   input  logic              accum_36,
   input  logic              accum_37,
   input  logic              accum_38,
   input  logic              accum_39,
   input  logic              satszp,
   output logic [DATA_W-1:0] q_c
);

   // Bits 38:31 must all equal bit 39 for the value to fit in 32 bits.
   logic [7:0] upper;
   assign upper = {accum_38, accum_37, accum_36, accum_35,
                   accum_34, accum_33, accum_32, d[31]};

   // In 16-bit mode the guard bits are d[30:15] against sign d[31].
   always_comb begin
      q_c = d;
      if (satszp) begin
         if (!accum_39 && (|upper))
            q_c = SAT_POS32;
         else if (accum_39 && !(&upper))
            q_c = SAT_NEG32;
      end else begin
         if (!d[31] && (|d[30:15]))
            q_c = SAT_POS16;
         else if (d[31] && !(&d[30:15]))
            q_c = SAT_NEG16;
      end
   end

endmodule

// File: rtl/j_mac_sequencer.sv
// Jerry DSP multiply-accumulate sequencer. Accepts a command, streams
// cmd_count signed 16x16 operand pairs through a registered multiplier into
// a 40-bit wrapping accumulator, then presents the saturated 32-bit result.
// Ports: clk/resetl (async active-low), abort (sync cancel),
//        cmd_* command handshake, op_* operand handshake,
//        res_valid/res_ready/res_q/res_sat result handshake.
module j_mac_sequencer
   import j_mac_sequencer_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic              clk,
   input  logic              resetl,
   input  logic              abort,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CNT_W-1:0]  cmd_count,
   input  logic              cmd_clear,
   input  logic              cmd_satszp,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [15:0]       op_a,
   input  logic [15:0]       op_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_q,
   output logic              res_sat
);

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          remaining_q;
   logic                      satszp_q;
   logic [ACC_W-1:0]          acc_q;
   logic signed [DATA_W-1:0]  prod_q;
   logic                      prod_v_q;
   logic signed [DATA_W-1:0]  mul;
   logic [DATA_W-1:0]         sat_q;
   logic                      cmd_fire, op_fire, res_fire;

   assign cmd_fire = cmd_valid & cmd_ready;
   assign op_fire  = op_valid & op_ready;
   assign res_fire = res_valid & res_ready;
   assign mul      = DATA_W'($signed(op_a)) * DATA_W'($signed(op_b));

   // Next-state logic; abort overrides every handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (cmd_fire) state_d = (cmd_count == '0) ? S_RESULT : S_RUN;
         S_RUN:    if (op_fire && (remaining_q == CNT_W'(1))) state_d = S_DRAIN;
         S_DRAIN:  state_d = S_RESULT;
         S_RESULT: if (res_fire) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   // State register with handshake flags registered from the next state.
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         state_q   <= S_IDLE;
         cmd_ready <= 1'b1;
         op_ready  <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_ready <= (state_d == S_IDLE);
         op_ready  <= (state_d == S_RUN);
         res_valid <= (state_d == S_RESULT);
      end
   end

   // Datapath: abort discards the pending product and freezes acc/counter.
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         remaining_q <= '0;
         satszp_q    <= 1'b0;
         acc_q       <= '0;
         prod_q      <= '0;
         prod_v_q    <= 1'b0;
      end else if (abort) begin
         prod_v_q <= 1'b0;
      end else begin
         prod_v_q <= op_fire;
         if (op_fire) begin
            prod_q      <= mul;
            remaining_q <= remaining_q - CNT_W'(1);
         end
         if (cmd_fire) begin
            remaining_q <= cmd_count;
            satszp_q    <= cmd_satszp;
            if (cmd_clear) acc_q <= '0;
         end else if (prod_v_q) begin
            acc_q <= acc_q + {{(ACC_W-DATA_W){prod_q[DATA_W-1]}}, prod_q};
         end
      end
   end

   j_saturate u_sat (
      .d        (acc_q[31:0]),
      .accum_32 (acc_q[32]),
      .accum_33 (acc_q[33]),
      .accum_34 (acc_q[34]),
      .accum_35 (acc_q[35]),
      .accum_36 (acc_q[36]),
      .accum_37 (acc_q[37]),
      .accum_38 (acc_q[38]),
      .accum_39 (acc_q[39]),
      .satszp   (satszp_q),
      .q_c      (sat_q)
   );

   // Result is held because acc does not move while in RESULT.
   assign res_q   = sat_q;
   assign res_sat = (sat_q != acc_q[31:0]);

endmodule

// File: tb/tb_j_mac_sequencer.sv
// Directed testbench for j_mac_sequencer with a value-level model of the
// accumulator and saturation rules.
module tb_j_mac_sequencer;

   logic        clk, resetl, abort;
   logic        cmd_valid, cmd_ready, cmd_clear, cmd_satszp;
   logic [7:0]  cmd_count;
   logic        op_valid, op_ready;
   logic [15:0] op_a, op_b;
   logic        res_valid, res_ready, res_sat;
   logic [31:0] res_q;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: running accumulator value and latched saturation mode.
   logic [39:0] m_acc   = '0;
   bit          m_sat32 = 1'b0;
   logic [31:0] cmp_exp;

   j_mac_sequencer #(.CNT_W(8)) dut (
      .clk        (clk),
      .resetl     (resetl),
      .abort      (abort),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_count  (cmd_count),
      .cmd_clear  (cmd_clear),
      .cmd_satszp (cmd_satszp),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_q      (res_q),
      .res_sat    (res_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0b, want %0b", name, act, exp);
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h, want %08h", name, act, exp);
   endtask

   task automatic chk40(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %010h, want %010h", name, act, exp);
   endtask

   // Clamp by numeric range rather than by bit patterns.
   function automatic logic [31:0] model_q(input logic [39:0] acc, input bit s32);
      longint v;
      int     d;
      if (s32) begin
         v = longint'($signed(acc));
         if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
         if (v < -64'sd2147483648) return 32'h8000_0000;
         return acc[31:0];
      end
      d = $signed(acc[31:0]);
      if (d > 32767)  return 32'h0000_7FFF;
      if (d < -32768) return 32'hFFFF_8000;
      return acc[31:0];
   endfunction

   function automatic logic [39:0] model_add(input logic [39:0] acc,
                                             input logic [15:0] a, input logic [15:0] b);
      longint pa, pb;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return acc + 40'(pa * pb);
   endfunction

   // Every cycle a result is presented it must match the model.
   always @(negedge clk) begin
      if (resetl === 1'b1 && res_valid === 1'b1) begin
         cmp_exp = model_q(m_acc, m_sat32);
         chk32("cmp_res_q", res_q, cmp_exp);
         chk1("cmp_res_sat", res_sat, cmp_exp != m_acc[31:0]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_cmd(input int n, input bit clr, input bit s32, input string tag);
      cmd_count  = 8'(n);
      cmd_clear  = clr;
      cmd_satszp = s32;
      cmd_valid  = 1'b1;
      @(negedge clk);
      chk1({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      if (clr) m_acc = '0;
      m_sat32 = s32;
   endtask

   // Full command: n pairs (a,b) with 'gap' idle cycles between pairs,
   // result held for 'hold' cycles before res_ready.
   task automatic run_cmd(input int n, input bit clr, input bit s32,
                          input logic [15:0] a, input logic [15:0] b,
                          input int gap, input int hold,
                          input logic [31:0] want_q, input logic want_sat,
                          input string tag);
      logic [31:0] held;
      accept_cmd(n, clr, s32, tag);
      for (int i = 0; i < n; i++) begin
         if (i > 0) repeat (gap) tick();
         op_valid = 1'b1;
         op_a     = a;
         op_b     = b;
         @(negedge clk);
         chk1({tag, "_op_ready"}, op_ready, 1'b1);
         chk1({tag, "_cmd_busy"}, cmd_ready, 1'b0);
         tick();
         op_valid = 1'b0;
         m_acc = model_add(m_acc, a, b);
      end
      if (n > 0) begin
         @(negedge clk);
         chk1({tag, "_drain_rv"}, res_valid, 1'b0);
         chk1({tag, "_drain_opr"}, op_ready, 1'b0);
         tick();
      end
      @(negedge clk);
      chk1({tag, "_res_valid"}, res_valid, 1'b1);
      chk32({tag, "_res_q"}, res_q, want_q);
      chk1({tag, "_res_sat"}, res_sat, want_sat);
      held = res_q;
      for (int h = 1; h < hold; h++) begin
         @(negedge clk);
         chk1({tag, "_hold_rv"}, res_valid, 1'b1);
         chk32({tag, "_hold_q"}, res_q, held);
         chk1({tag, "_hold_cmdr"}, cmd_ready, 1'b0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      @(negedge clk);
      chk1({tag, "_idle_cmdr"}, cmd_ready, 1'b1);
      chk1({tag, "_idle_rv"}, res_valid, 1'b0);
      tick();
   endtask

   initial begin
      resetl     = 1'b0;
      abort      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_count  = '0;
      cmd_clear  = 1'b0;
      cmd_satszp = 1'b0;
      op_valid   = 1'b0;
      op_a       = '0;
      op_b       = '0;
      res_ready  = 1'b0;

      @(negedge clk);
      chk1("rst_cmd_ready", cmd_ready, 1'b1);
      chk1("rst_op_ready", op_ready, 1'b0);
      chk1("rst_res_valid", res_valid, 1'b0);
      chk32("rst_res_q", res_q, 32'h0);
      chk1("rst_res_sat", res_sat, 1'b0);
      tick();
      resetl = 1'b1;
      tick();

      // Basic accumulate, 32-bit and 16-bit modes.
      run_cmd(2, 1'b1, 1'b1, 16'h4000, 16'h4000, 0, 1, 32'h2000_0000, 1'b0, "s1");
      run_cmd(2, 1'b1, 1'b0, 16'h4000, 16'h4000, 0, 1, 32'h0000_7FFF, 1'b1, "s2");

      // Positive overflow past 32 bits.
      run_cmd(4, 1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 0, 1, 32'h7FFF_FFFF, 1'b1, "s3");
      chk40("s3_model_acc", m_acc, 40'h00_FFFC_0004);

      // Negative overflow, then a zero-count chained command.
      run_cmd(4, 1'b1, 1'b1, 16'h8000, 16'h7FFF, 0, 1, 32'h8000_0000, 1'b1, "s4");
      chk40("s4_model_acc", m_acc, 40'hFF_0002_0000);
      run_cmd(0, 1'b0, 1'b1, 16'h0, 16'h0, 0, 1, 32'h8000_0000, 1'b1, "s4_zero");

      // Result back-pressure, then operand gaps.
      run_cmd(2, 1'b1, 1'b1, 16'h4000, 16'h4000, 0, 5, 32'h2000_0000, 1'b0, "s5_hold");
      run_cmd(2, 1'b1, 1'b1, 16'h4000, 16'h4000, 3, 1, 32'h2000_0000, 1'b0, "s5_gap");

      // Abort after the first product has been accumulated; abort beats op accept.
      accept_cmd(3, 1'b1, 1'b1, "s6");
      op_valid = 1'b1;
      op_a = 16'hFFFD;
      op_b = 16'h0007;
      tick();
      m_acc = model_add(m_acc, 16'hFFFD, 16'h0007);
      op_valid = 1'b0;
      tick();
      abort    = 1'b1;
      op_valid = 1'b1;
      op_a = 16'h0100;
      op_b = 16'h0100;
      tick();
      abort    = 1'b0;
      op_valid = 1'b0;
      @(negedge clk);
      chk1("s6_abort_cmdr", cmd_ready, 1'b1);
      chk1("s6_abort_opr", op_ready, 1'b0);
      chk1("s6_abort_rv", res_valid, 1'b0);
      tick();
      chk40("s6_model_acc", m_acc, 40'hFF_FFFF_FFEB);
      run_cmd(0, 1'b0, 1'b1, 16'h0, 16'h0, 0, 1, 32'hFFFF_FFEB, 1'b0, "s6_chk");

      // Abort while a product is still pending: that product is discarded.
      accept_cmd(2, 1'b0, 1'b1, "s6b");
      op_valid = 1'b1;
      op_a = 16'h0100;
      op_b = 16'h0100;
      tick();
      op_valid = 1'b0;
      abort    = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      chk1("s6b_abort_rv", res_valid, 1'b0);
      tick();
      run_cmd(0, 1'b0, 1'b1, 16'h0, 16'h0, 0, 1, 32'hFFFF_FFEB, 1'b0, "s6b_chk");

      // Asynchronous reset in the middle of RUN.
      accept_cmd(3, 1'b1, 1'b1, "s7");
      op_valid = 1'b1;
      op_a = 16'h4000;
      op_b = 16'h4000;
      tick();
      op_valid = 1'b0;
      m_acc = model_add(m_acc, 16'h4000, 16'h4000);
      tick();
      @(negedge clk);
      chk32("s7_pre_rst_q", res_q, 32'h1000_0000);
      chk1("s7_pre_rst_opr", op_ready, 1'b1);
      #2;
      resetl = 1'b0;
      m_acc   = '0;
      m_sat32 = 1'b0;
      #1;
      chk1("s7_rst_cmd_ready", cmd_ready, 1'b1);
      chk1("s7_rst_op_ready", op_ready, 1'b0);
      chk1("s7_rst_res_valid", res_valid, 1'b0);
      chk32("s7_rst_res_q", res_q, 32'h0);
      chk1("s7_rst_res_sat", res_sat, 1'b0);
      tick();
      resetl = 1'b1;
      tick();
      run_cmd(0, 1'b0, 1'b1, 16'h0, 16'h0, 0, 1, 32'h0, 1'b0, "s7_chk");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
      $fatal(1);
   end

endmodule

// File: doc/j_mac_sequencer.md
# j_mac_sequencer

Sequencer for the Jerry DSP multiply-accumulate path. It accepts a MAC command, streams N signed 16x16 operand pairs through a registered multiplier into a 40-bit accumulator, then presents the saturated 32-bit result. Saturation is selectable between 16-bit and 32-bit range. The block sits between the DSP instruction decode (command and operand source) and the register write-back port (result sink).

## Interface
Parameters:
- `CNT_W`, default 8: width of the product-count field.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `resetl`  in  1  asynchronous, active-low reset.
- `abort`  in  1  synchronous cancel of the command in progress.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both high.
- `cmd_count`  in  CNT_W  number of products to accumulate; 0 is legal.
- `cmd_clear`  in  1  zero the accumulator at command accept.
- `cmd_satszp`  in  1  1 = 32-bit saturation, 0 = 16-bit saturation.
- `op_valid`  in  1  operand pair offered.
- `op_ready`  out  1  operand pair accepted when both high.
- `op_a`  in  16  signed multiplicand.
- `op_b`  in  16  signed multiplier.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when both high.
- `res_q`  out  32  saturated result.
- `res_sat`  out  1  result was clamped.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - RUN: `op_ready`=1.
  - DRAIN.
  - RESULT: `res_valid`=1.
- IDLE→RUN on cmd accept with `cmd_count`≠0; IDLE→RESULT on accept with `cmd_count`=0.
- At cmd accept:
  - latch `cmd_satszp` and the count into the remaining counter;
  - if `cmd_clear`, zero the accumulator; otherwise the accumulator keeps its value (chaining).
- RUN, op accept:
  - `prod` ← `op_a`×`op_b` (32-bit signed), `prod_v` ← 1;
  - remaining decrements;
  - on the accept with remaining=1, go to DRAIN.
- Accumulate: whenever `prod_v`=1, acc ← acc + sign-extend40(`prod`), wrapping mod 2^40 with no internal saturation. `prod_v` clears when no new operand is accepted.
- DRAIN→RESULT unconditionally after one cycle, during which the last product is accumulated.
- RESULT→IDLE on res accept.
- Saturation is combinational from acc and the latched satszp. Let d = acc[31:0].
  - 32-bit mode:
    - acc[39]=0 and any of acc[38:31] set → 0x7FFFFFFF;
    - acc[39]=1 and not all of acc[38:31] set → 0x80000000;
    - else d.
  - 16-bit mode (acc[39:32] ignored):
    - d[31]=0 and any of d[30:15] set → 0x00007FFF;
    - d[31]=1 and not all of d[30:15] set → 0xFFFF8000;
    - else d.
  - `res_sat`=1 when a clamp applied.
- `abort` (any state) → IDLE next cycle; `prod_v` cleared, pending product discarded, accumulator and counter frozen, no result produced. `abort` wins over any simultaneous handshake.

## Timing
- Reset values:
  - state IDLE;
  - acc=0, `prod`=0, `prod_v`=0, remaining=0, satszp=0;
  - `cmd_ready`=1, `op_ready`=0, `res_valid`=0, `res_q`=0, `res_sat`=0.
- Throughput: one operand pair per cycle in RUN. `op_valid` low stalls without penalty.
- Latency:
  - last operand accepted in cycle T; DRAIN in T+1; `res_valid` first high in T+2.
  - `cmd_count`=0: `res_valid` high the cycle after cmd accept.
- `res_q` and `res_sat` stay stable while `res_valid`=1 and `res_ready`=0.
- `cmd_ready` is low from cmd accept until the cycle after res accept. There is no command overlap.
- Reset mid-operation: immediate return to reset values; the accumulator is lost.

## Structure
- Shared package (jerry DSP package):
  - state enum;
  - ACC_W=40;
  - the clamp constants 0x7FFFFFFF, 0x80000000, 0x00007FFF, 0xFFFF8000.
- Saturation is the existing `j_saturate` block instantiated as one sub-module: `d`=acc[31:0], `accum_32..39`=acc[39:32], `satszp`=latched mode.
- `res_sat` is derived locally by comparing `res_q` with acc[31:0].

## Test plan
- Scenario 1:
  - stimulus: clear, count=2, 32-bit mode, pairs (0x4000,0x4000)×2;
  - response: `res_q`=0x20000000, `res_sat`=0, `res_valid` at T+2.
- Scenario 2:
  - stimulus: same operands, 16-bit mode;
  - response: `res_q`=0x00007FFF, `res_sat`=1.
- Scenario 3:
  - stimulus: clear, count=4, 32-bit mode, pairs (0x7FFF,0x7FFF);
  - response: acc=0x00FFFC0004, `res_q`=0x7FFFFFFF, `res_sat`=1.
- Scenario 4:
  - stimulus: clear, count=4, pairs (0x8000,0x7FFF);
  - response: acc=0xFF00020000, `res_q`=0x80000000.
  - follow-up: count=0 without clear → same result one cycle after accept.
- Scenario 5:
  - stimulus: `res_ready` held low 5 cycles;
  - response: `res_q` stable, `cmd_ready`=0 throughout; IDLE the cycle after accept.
  - follow-up: `op_valid` gaps of 3 cycles only delay the result by the gap.
- Scenario 6:
  - stimulus: abort after 1 of 3 operands;
  - response: IDLE next cycle, no `res_valid`, accumulator holds first product only (verify via count=0 follow-up).
  - follow-up: `resetl` low mid-RUN → all outputs at reset values asynchronously.
